adcdac_uart_ctrl: RTL and testbench
===================================

Name: adcdac_uart_ctrl

Overview:
Parametrised UART controller for the FNAL 2Gsps ADC/DAC control link over ZDOK. It provides a runtime-programmable baud generator, 16x-oversampled TX and RX engines, configurable parity and stop bits, and error reporting. TX and RX FIFOs have parametrised depth, and RX uses a valid/ready read interface. LVDS IBUFDS/OBUFDS stay in the wrapper above; this block sees single-ended serial lines.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9)
FIFO_DEPTH, 16, entries per TX and RX FIFO (power of 2, >=2)
DIV_W, 16, width of baud_div

Ports:
fpga_clk  in  1  sole clock
user_rst  in  1  synchronous active-high reset, whole block
baud_div  in  DIV_W  fpga_clk cycles per 16x tick; values <2 are treated as 2
parity_en  in  1  1 = parity bit present
parity_odd  in  1  1 = odd parity, 0 = even parity
two_stop  in  1  1 = TX sends 2 stop bits
user_tx_data  in  DATA_BITS  byte to send
user_tx_val  in  1  write strobe into the TX FIFO
user_tx_full  out  1  TX FIFO full
user_tx_idle  out  1  TX FIFO empty and TX engine in IDLE
user_rx_data  out  DATA_BITS  RX FIFO head data
user_rx_frame_err  out  1  head entry: stop bit sampled 0
user_rx_parity_err  out  1  head entry: parity mismatch
user_rx_val  out  1  RX FIFO non-empty
user_rx_rdy  in  1  pops the head when user_rx_val=1
user_rx_full  out  1  RX FIFO full
user_rx_overflow  out  1  sticky: a byte was dropped because the RX FIFO was full
user_rx_ovf_clr  in  1  clears user_rx_overflow
serial_tx  out  1  line out, idle high
serial_rx  in  1  line in, asynchronous

Behaviour:
- Reset values: serial_tx=1, all FIFOs empty, user_tx_full=0, user_tx_idle=1, user_rx_val=0, user_rx_full=0, user_rx_overflow=0, data/err outputs=0. Baud counter=0. RX synchroniser=2'b11.
- Baud tick:
  - Counter runs 0..max(baud_div,2)-1; tick is a one-cycle pulse when the counter equals the terminal value, and the counter then wraps to 0.
  - A baud_div change takes effect at the next wrap.
  - Bit period = 16 ticks. Line rate = fclk/(16*div).
- Configuration inputs (parity_en, parity_odd, two_stop) are sampled at frame start (TX leaving IDLE, RX detecting start). Changes mid-frame do not affect the current frame.
- TX FIFO:
  - A write with user_tx_val=1 while full is dropped; the FIFO is unchanged.
  - Simultaneous write and engine pop is legal when the FIFO is not empty.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
  - Leaves IDLE on the first tick with the FIFO non-empty; the FIFO pops in that same cycle.
  - Each state holds its line value for 16 ticks. Data is sent LSB first.
  - Parity bit = XOR(data) XOR parity_odd.
  - Back-to-back frames have no extra idle gap.
- RX path:
  - 2-flop synchroniser on serial_rx.
  - IDLE: synchronised line = 0 -> START and reset the tick counter.
  - START: at tick 8, sample. A 1 means a false start -> IDLE with nothing pushed. A 0 -> DATA.
  - DATA and PARITY: sample every 16 ticks (bit centre).
  - STOP: sample once.
    - Push {parity_err, frame_err, data} in the next cycle.
    - If stop=1 -> IDLE. If stop=0 (break or frame error) -> WAIT_HIGH until the line is 1, then IDLE.
  - RX checks only one stop bit.
- RX FIFO:
  - First-word-fall-through: user_rx_val/data/flags show the head. Pop happens when user_rx_val & user_rx_rdy.
  - user_rx_val rises 1 cycle after the push.
  - Push while full: entry dropped, user_rx_overflow<=1. Push and pop in the same cycle while full: the pop frees space, so the push succeeds.
  - user_rx_ovf_clr and an overflow event in the same cycle: overflow wins (stays 1).
- Reset mid-frame: next cycle serial_tx=1, both FSMs in IDLE, both FIFOs emptied, partial frames discarded.
- Occupancy counters are log2(FIFO_DEPTH)+1 bits wide, so full and empty are distinguishable without wasting an entry.

Decomposition:
- Package adcdac_uart_pkg holds:
  - TX/RX state enums
  - OVERSAMPLE=16 and MID_SAMPLE=8
  - RX entry width constant DATA_BITS+2 as a function of DATA_BITS
- One sub-module, adcdac_uart_fifo: parametrised width/depth sync FWFT FIFO with full/empty, used twice (TX width DATA_BITS, RX width DATA_BITS+2).
- Baud generator, TX FSM and RX FSM are inline.

Test Plan:
- Loopback serial_tx->serial_rx, baud_div=4, 8N1, write 0xA5 -> serial_tx low for 64 cycles, then bits 1,0,1,0,0,1,0,1; user_rx_data=0xA5 with both err flags 0 about 640 cycles after the write.
- Even parity, tx 0x07 -> parity bit=1 on the line. Inject a flipped parity bit on the RX side -> user_rx_parity_err=1, data=0x07.
- Drive a 0x3C frame with stop=0, then hold low 200 cycles -> frame_err=1. No second byte is pushed until the line returns high.
- FIFO_DEPTH=4, user_rx_rdy=0, 5 frames received -> user_rx_full=1 after 4, user_rx_overflow=1. Pop order is bytes 1..4. user_rx_ovf_clr clears the flag.
- 20-cycle low glitch on serial_rx with baud_div=4 -> false start, user_rx_val stays 0.
- Assert user_rst during the DATA bit 3 of a TX frame -> serial_tx=1 next cycle, user_tx_idle=1, no RX byte produced.

Source files
------------

// File: rtl/adcdac_uart_pkg.sv
// Shared types and constants for the ADC/DAC control-link UART.
// Holds the TX/RX state encodings and the oversampling constants.
package adcdac_uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // An RX entry carries the payload plus the frame and parity error flags.
    function automatic int rx_entry_w(input int data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/adcdac_uart_fifo.sv
// Synchronous first-word-fall-through FIFO. The head is visible whenever the
// FIFO is non-empty; a write to a full FIFO succeeds only if a pop happens in the same cycle.
module adcdac_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             rd_ok;
    logic             wr_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    // Outputs read as zero while empty so the user sees clean data after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
        end
    end

endmodule

// File: rtl/adcdac_uart_ctrl.sv
// UART controller for the ADC/DAC ZDOK control link: programmable baud tick,
// 16x-oversampled TX/RX engines with optional parity, TX and RX FIFOs.
module adcdac_uart_ctrl
    import adcdac_uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 fpga_clk,
    input  logic                 user_rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    input  logic [DATA_BITS-1:0] user_tx_data,
    input  logic                 user_tx_val,
    output logic                 user_tx_full,
    output logic                 user_tx_idle,
    output logic [DATA_BITS-1:0] user_rx_data,
    output logic                 user_rx_frame_err,
    output logic                 user_rx_parity_err,
    output logic                 user_rx_val,
    input  logic                 user_rx_rdy,
    output logic                 user_rx_full,
    output logic                 user_rx_overflow,
    input  logic                 user_rx_ovf_clr,
    output logic                 serial_tx,
    input  logic                 serial_rx
);
    localparam int         RX_W      = rx_entry_w(DATA_BITS);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);

    // Baud tick: the divisor is latched at each wrap so a change never shortens a running period.
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] baud_cnt_reg;
    logic             tick;

    assign div_eff = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
    assign tick    = (baud_cnt_reg == div_reg - 1'b1);

    always_ff @(posedge fpga_clk) begin
        if (user_rst || tick) begin
            baud_cnt_reg <= '0;
            div_reg      <= div_eff;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
        end
    end

    logic                 tx_pop;
    logic                 tx_empty;
    logic [DATA_BITS-1:0] tx_head;

    adcdac_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (fpga_clk),
        .srst    (user_rst),
        .wr_en   (user_tx_val),
        .wr_data (user_tx_data),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (user_tx_full),
        .empty   (tx_empty)
    );

    tx_state_t            tx_state_reg;
    logic [3:0]           tx_tick_reg;
    logic [3:0]           tx_bit_reg;
    logic [DATA_BITS-1:0] tx_shift_reg;
    logic                 tx_par_reg;
    logic                 tx_par_en_reg;
    logic                 tx_two_stop_reg;
    logic                 tx_bit_end;
    logic                 tx_last_stop;

    assign tx_bit_end   = tick && (tx_tick_reg == LAST_TICK);
    assign tx_last_stop = (tx_state_reg == TX_STOP2) ||
                          (tx_state_reg == TX_STOP1 && !tx_two_stop_reg);
    // Popping straight out of the final stop bit keeps back-to-back frames gapless.
    assign tx_pop       = !tx_empty && ((tx_state_reg == TX_IDLE && tick) ||
                                        (tx_last_stop && tx_bit_end));
    assign user_tx_idle = tx_empty && (tx_state_reg == TX_IDLE);

    always_ff @(posedge fpga_clk) begin
        if (user_rst) begin
            tx_state_reg    <= TX_IDLE;
            tx_tick_reg     <= '0;
            tx_bit_reg      <= '0;
            tx_shift_reg    <= '0;
            tx_par_reg      <= 1'b0;
            tx_par_en_reg   <= 1'b0;
            tx_two_stop_reg <= 1'b0;
            serial_tx       <= 1'b1;
        end else if (tx_pop) begin
            tx_state_reg    <= TX_START;
            tx_tick_reg     <= '0;
            tx_shift_reg    <= tx_head;
            tx_par_reg      <= (^tx_head) ^ parity_odd;
            tx_par_en_reg   <= parity_en;
            tx_two_stop_reg <= two_stop;
            serial_tx       <= 1'b0;
        end else if (tick && tx_state_reg != TX_IDLE) begin
            tx_tick_reg <= tx_tick_reg + 1'b1;
            if (tx_tick_reg == LAST_TICK) begin
                case (tx_state_reg)
                    TX_START: begin
                        tx_state_reg <= TX_DATA;
                        tx_bit_reg   <= '0;
                        serial_tx    <= tx_shift_reg[0];
                    end
                    TX_DATA: begin
                        if (tx_bit_reg == LAST_BIT) begin
                            tx_state_reg <= tx_par_en_reg ? TX_PARITY : TX_STOP1;
                            serial_tx    <= tx_par_en_reg ? tx_par_reg : 1'b1;
                        end else begin
                            tx_bit_reg   <= tx_bit_reg + 1'b1;
                            tx_shift_reg <= tx_shift_reg >> 1;
                            serial_tx    <= tx_shift_reg[1];
                        end
                    end
                    TX_PARITY: begin
                        tx_state_reg <= TX_STOP1;
                        serial_tx    <= 1'b1;
                    end
                    TX_STOP1: tx_state_reg <= tx_two_stop_reg ? TX_STOP2 : TX_IDLE;
                    default:  tx_state_reg <= TX_IDLE;
                endcase
            end
        end
    end

    logic [1:0]           rx_sync_reg;
    logic                 rx_s;
    rx_state_t            rx_state_reg;
    logic [3:0]           rx_tick_reg;
    logic [3:0]           rx_bit_reg;
    logic [DATA_BITS-1:0] rx_shift_reg;
    logic                 rx_par_en_reg;
    logic                 rx_odd_reg;
    logic                 rx_par_err_reg;
    logic                 rx_frame_err_reg;
    logic                 rx_push_reg;

    assign rx_s = rx_sync_reg[1];

    always_ff @(posedge fpga_clk) begin
        if (user_rst) begin
            rx_sync_reg      <= 2'b11;
            rx_state_reg     <= RX_IDLE;
            rx_tick_reg      <= '0;
            rx_bit_reg       <= '0;
            rx_shift_reg     <= '0;
            rx_par_en_reg    <= 1'b0;
            rx_odd_reg       <= 1'b0;
            rx_par_err_reg   <= 1'b0;
            rx_frame_err_reg <= 1'b0;
            rx_push_reg      <= 1'b0;
        end else begin
            rx_sync_reg <= {rx_sync_reg[0], serial_rx};
            rx_push_reg <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_state_reg     <= RX_START;
                        rx_tick_reg      <= '0;
                        rx_par_en_reg    <= parity_en;
                        rx_odd_reg       <= parity_odd;
                        rx_par_err_reg   <= 1'b0;
                        rx_frame_err_reg <= 1'b0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_tick_reg == MID_TICK) begin
                            rx_tick_reg  <= '0;
                            rx_bit_reg   <= '0;
                            rx_state_reg <= rx_s ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tick_reg <= rx_tick_reg + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rx_tick_reg <= rx_tick_reg + 1'b1;
                        if (rx_tick_reg == LAST_TICK) begin
                            rx_shift_reg <= {rx_s, rx_shift_reg[DATA_BITS-1:1]};
                            if (rx_bit_reg == LAST_BIT) begin
                                rx_state_reg <= rx_par_en_reg ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_bit_reg <= rx_bit_reg + 1'b1;
                            end
                        end
                    end
                end
                RX_PARITY: begin
                    if (tick) begin
                        rx_tick_reg <= rx_tick_reg + 1'b1;
                        if (rx_tick_reg == LAST_TICK) begin
                            rx_par_err_reg <= rx_s ^ (^rx_shift_reg) ^ rx_odd_reg;
                            rx_state_reg   <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        rx_tick_reg <= rx_tick_reg + 1'b1;
                        if (rx_tick_reg == LAST_TICK) begin
                            rx_frame_err_reg <= !rx_s;
                            rx_push_reg      <= 1'b1;
                            rx_state_reg     <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s) begin
                        rx_state_reg <= RX_IDLE;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    logic [RX_W-1:0] rx_entry;
    logic [RX_W-1:0] rx_head;
    logic            rx_empty;
    logic            rx_pop;
    logic            rx_drop;

    assign rx_entry = {rx_par_err_reg, rx_frame_err_reg, rx_shift_reg};

    adcdac_uart_fifo #(.WIDTH(RX_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (fpga_clk),
        .srst    (user_rst),
        .wr_en   (rx_push_reg),
        .wr_data (rx_entry),
        .rd_en   (user_rx_rdy),
        .rd_data (rx_head),
        .full    (user_rx_full),
        .empty   (rx_empty)
    );

    assign user_rx_val = !rx_empty;
    assign {user_rx_parity_err, user_rx_frame_err, user_rx_data} = rx_head;
    assign rx_pop  = user_rx_val && user_rx_rdy;
    assign rx_drop = rx_push_reg && user_rx_full && !rx_pop;

    always_ff @(posedge fpga_clk) begin
        if (user_rst) begin
            user_rx_overflow <= 1'b0;
        end else if (rx_drop) begin
            user_rx_overflow <= 1'b1;
        end else if (user_rx_ovf_clr) begin
            user_rx_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adcdac_uart_ctrl.sv
// Self-checking bench for adcdac_uart_ctrl: loopback and bench-driven serial frames
// checked against expectations computed from frame-level rules.
module tb_adcdac_uart_ctrl;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int DIV   = 4;
    localparam int BT    = 16 * DIV;

    logic          fpga_clk = 1'b0;
    logic          user_rst = 1'b1;
    logic [DW-1:0] baud_div = DW'(DIV);
    logic          parity_en = 1'b0;
    logic          parity_odd = 1'b0;
    logic          two_stop = 1'b0;
    logic [DB-1:0] user_tx_data = '0;
    logic          user_tx_val = 1'b0;
    logic          user_tx_full;
    logic          user_tx_idle;
    logic [DB-1:0] user_rx_data;
    logic          user_rx_frame_err;
    logic          user_rx_parity_err;
    logic          user_rx_val;
    logic          user_rx_rdy = 1'b0;
    logic          user_rx_full;
    logic          user_rx_overflow;
    logic          user_rx_ovf_clr = 1'b0;
    logic          serial_tx;
    logic          serial_rx;
    logic          loop_en = 1'b0;
    logic          rx_line = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    assign serial_rx = loop_en ? serial_tx : rx_line;

    always #5 fpga_clk = ~fpga_clk;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    adcdac_uart_ctrl #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
        .fpga_clk           (fpga_clk),
        .user_rst           (user_rst),
        .baud_div           (baud_div),
        .parity_en          (parity_en),
        .parity_odd         (parity_odd),
        .two_stop           (two_stop),
        .user_tx_data       (user_tx_data),
        .user_tx_val        (user_tx_val),
        .user_tx_full       (user_tx_full),
        .user_tx_idle       (user_tx_idle),
        .user_rx_data       (user_rx_data),
        .user_rx_frame_err  (user_rx_frame_err),
        .user_rx_parity_err (user_rx_parity_err),
        .user_rx_val        (user_rx_val),
        .user_rx_rdy        (user_rx_rdy),
        .user_rx_full       (user_rx_full),
        .user_rx_overflow   (user_rx_overflow),
        .user_rx_ovf_clr    (user_rx_ovf_clr),
        .serial_tx          (serial_tx),
        .serial_rx          (serial_rx)
    );

    initial begin
        repeat (80000) @(posedge fpga_clk);
        $display("FAIL watchdog: simulation still running after 80000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic tx_write(input logic [7:0] d);
        user_tx_data = d;
        user_tx_val  = 1'b1;
        @(negedge fpga_clk);
        user_tx_val  = 1'b0;
    endtask

    task automatic pop_one();
        user_rx_rdy = 1'b1;
        @(negedge fpga_clk);
        user_rx_rdy = 1'b0;
    endtask

    task automatic wait_val(input int budget, output bit ok);
        for (int n = 0; n < budget && !user_rx_val; n++) @(negedge fpga_clk);
        ok = user_rx_val;
    endtask

    task automatic wait_fall(input int budget, output bit ok);
        for (int n = 0; n < budget && serial_tx; n++) @(negedge fpga_clk);
        ok = !serial_tx;
    endtask

    // Serial frame on the RX line: start, LSB-first data, optional parity, one stop bit.
    task automatic drive_frame(input logic [7:0] d, input logic pen, input logic podd,
                               input logic flip, input logic stopv);
        logic [10:0] bits;
        int nb;
        bits = '0;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin bits[nb] = d[i]; nb++; end
        if (pen) begin bits[nb] = (^d) ^ podd ^ flip; nb++; end
        bits[nb] = stopv; nb++;
        for (int i = 0; i < nb; i++) begin
            rx_line = bits[i];
            repeat (BT) @(negedge fpga_clk);
        end
    endtask

    task automatic test_reset();
        user_rst = 1'b1;
        repeat (3) @(negedge fpga_clk);
        checks++;
        if ({serial_tx, user_tx_idle, user_tx_full, user_rx_val, user_rx_full, user_rx_overflow} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 110000",
                     {serial_tx, user_tx_idle, user_tx_full, user_rx_val, user_rx_full, user_rx_overflow});
        end
        checks++;
        if ({user_rx_parity_err, user_rx_frame_err, user_rx_data} !== 10'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 000", {user_rx_parity_err, user_rx_frame_err, user_rx_data});
        end
        user_rst = 1'b0;
        @(negedge fpga_clk);
    endtask

    task automatic test_loopback_8n1();
        logic [7:0] d;
        int t_wr, n, lat;
        bit ok;
        d = 8'hA5;
        loop_en = 1'b1; parity_en = 1'b0; two_stop = 1'b0;
        t_wr = cyc;
        tx_write(d);
        wait_fall(4 * DIV, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL l8n1_start: serial_tx never went low"); end
        n = 0;
        while (!serial_tx && n < 2 * BT) begin @(negedge fpga_clk); n++; end
        checks++;
        if (n != BT) begin errors++; $display("FAIL l8n1_start_len: got %0d cycles expected %0d", n, BT); end
        repeat (BT / 2) @(negedge fpga_clk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (serial_tx !== d[i]) begin
                errors++; $display("FAIL l8n1_bit%0d: got %b expected %b", i, serial_tx, d[i]);
            end
            repeat (BT) @(negedge fpga_clk);
        end
        checks++;
        if (serial_tx !== 1'b1) begin errors++; $display("FAIL l8n1_stop: got %b expected 1", serial_tx); end
        wait_val(2 * BT, ok);
        lat = cyc - t_wr;
        checks++;
        if (!ok || lat < 600 || lat > 660) begin
            errors++; $display("FAIL l8n1_latency: got %0d cycles (val=%b) expected 600..660", lat, user_rx_val);
        end
        checks++;
        if ({user_rx_parity_err, user_rx_frame_err, user_rx_data} !== {2'b00, d}) begin
            errors++; $display("FAIL l8n1_rx: got %h expected %h", {user_rx_parity_err, user_rx_frame_err, user_rx_data}, {2'b00, d});
        end
        pop_one();
        checks++;
        if (user_rx_val !== 1'b0) begin errors++; $display("FAIL l8n1_pop: val got %b expected 0", user_rx_val); end
        repeat (BT) @(negedge fpga_clk);
    endtask

    task automatic test_parity();
        logic [7:0] d;
        bit ok;
        d = 8'h07;
        loop_en = 1'b1; parity_en = 1'b1; parity_odd = 1'b0;
        tx_write(d);
        wait_fall(4 * DIV, ok);
        repeat (BT / 2 + 9 * BT) @(negedge fpga_clk);
        checks++;
        if (!ok || serial_tx !== ((^d) ^ 1'b0)) begin
            errors++; $display("FAIL par_line: got %b expected %b", serial_tx, (^d));
        end
        wait_val(2 * BT, ok);
        checks++;
        if (!ok || {user_rx_parity_err, user_rx_frame_err, user_rx_data} !== {2'b00, d}) begin
            errors++; $display("FAIL par_loop_rx: got %h expected %h", {user_rx_parity_err, user_rx_frame_err, user_rx_data}, {2'b00, d});
        end
        pop_one();
        repeat (BT) @(negedge fpga_clk);
        loop_en = 1'b0;
        drive_frame(d, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_val(BT, ok);
        checks++;
        if (!ok || {user_rx_parity_err, user_rx_frame_err, user_rx_data} !== {2'b10, d}) begin
            errors++; $display("FAIL par_inject: got %h expected %h", {user_rx_parity_err, user_rx_frame_err, user_rx_data}, {2'b10, d});
        end
        pop_one();
    endtask

    task automatic test_random_rx();
        logic [7:0] d;
        logic pen, podd, flip;
        bit ok;
        loop_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom); pen = 1'($urandom); podd = 1'($urandom); flip = 1'($urandom);
            parity_en = pen; parity_odd = podd;
            drive_frame(d, pen, podd, flip, 1'b1);
            wait_val(BT, ok);
            checks++;
            if (!ok || {user_rx_parity_err, user_rx_frame_err, user_rx_data} !== {pen & flip, 1'b0, d}) begin
                errors++; $display("FAIL rand_rx%0d: got %h expected %h", k,
                                   {user_rx_parity_err, user_rx_frame_err, user_rx_data}, {pen & flip, 1'b0, d});
            end
            pop_one();
        end
        parity_en = 1'b0; parity_odd = 1'b0;
    endtask

    task automatic test_frame_err();
        bit ok;
        loop_en = 1'b0; parity_en = 1'b0;
        drive_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_val(BT, ok);
        checks++;
        if (!ok || {user_rx_parity_err, user_rx_frame_err, user_rx_data} !== {2'b01, 8'h3C}) begin
            errors++; $display("FAIL ferr_rx: got %h expected %h", {user_rx_parity_err, user_rx_frame_err, user_rx_data}, {2'b01, 8'h3C});
        end
        pop_one();
        repeat (200) @(negedge fpga_clk);
        checks++;
        if (user_rx_val !== 1'b0) begin errors++; $display("FAIL ferr_low_hold: val got %b expected 0", user_rx_val); end
        rx_line = 1'b1;
        repeat (3 * BT) @(negedge fpga_clk);
        checks++;
        if (user_rx_val !== 1'b0) begin errors++; $display("FAIL ferr_release: val got %b expected 0", user_rx_val); end
    endtask

    task automatic test_overflow();
        logic [7:0] d [5];
        loop_en = 1'b0; parity_en = 1'b0; user_rx_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d[k] = 8'($urandom);
            drive_frame(d[k], 1'b0, 1'b0, 1'b0, 1'b1);
            if (k == 3) begin
                checks++;
                if ({user_rx_full, user_rx_overflow} !== 2'b10) begin
                    errors++; $display("FAIL ovf_full4: got %b expected 10", {user_rx_full, user_rx_overflow});
                end
            end
        end
        checks++;
        if ({user_rx_full, user_rx_overflow} !== 2'b11) begin
            errors++; $display("FAIL ovf_set: got %b expected 11", {user_rx_full, user_rx_overflow});
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({user_rx_val, user_rx_data} !== {1'b1, d[k]}) begin
                errors++; $display("FAIL ovf_pop%0d: got %h expected %h", k, {user_rx_val, user_rx_data}, {1'b1, d[k]});
            end
            pop_one();
        end
        checks++;
        if ({user_rx_val, user_rx_overflow} !== 2'b01) begin
            errors++; $display("FAIL ovf_drained: got %b expected 01", {user_rx_val, user_rx_overflow});
        end
        user_rx_ovf_clr = 1'b1;
        @(negedge fpga_clk);
        user_rx_ovf_clr = 1'b0;
        checks++;
        if (user_rx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", user_rx_overflow); end
    endtask

    task automatic test_false_start();
        logic [7:0] d;
        bit ok;
        loop_en = 1'b0; parity_en = 1'b0;
        rx_line = 1'b0;
        repeat (20) @(negedge fpga_clk);
        rx_line = 1'b1;
        repeat (400) @(negedge fpga_clk);
        checks++;
        if (user_rx_val !== 1'b0) begin errors++; $display("FAIL glitch: val got %b expected 0", user_rx_val); end
        d = 8'($urandom);
        drive_frame(d, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_val(BT, ok);
        checks++;
        if (!ok || {user_rx_parity_err, user_rx_frame_err, user_rx_data} !== {2'b00, d}) begin
            errors++; $display("FAIL glitch_recover: got %h expected %h", {user_rx_parity_err, user_rx_frame_err, user_rx_data}, {2'b00, d});
        end
        pop_one();
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        logic [7:0] exp_q [$];
        logic [7:0] e;
        int nbits, fall_cyc, idle_cyc;
        for (int run = 0; run < 2; run++) begin
            parity_en = 1'($urandom); parity_odd = 1'($urandom); two_stop = 1'($urandom);
            nbits = 10 + int'(parity_en) + int'(two_stop);
            loop_en = 1'b1; user_rx_rdy = 1'b1;
            fall_cyc = -1; idle_cyc = -1;
            exp_q.delete();
            checks++;
            if (user_tx_idle !== 1'b1) begin errors++; $display("FAIL b2b_idle_before%0d: got %b expected 1", run, user_tx_idle); end
            // Six writes in a row: one is taken by the engine, four fill the FIFO, the sixth is dropped.
            for (int k = 0; k < 6; k++) begin
                w = 8'($urandom);
                if (k < 5) exp_q.push_back(w);
                user_tx_data = w; user_tx_val = 1'b1;
                @(negedge fpga_clk);
                if (fall_cyc < 0 && !serial_tx) fall_cyc = cyc;
            end
            user_tx_val = 1'b0;
            checks++;
            if (user_tx_full !== 1'b1) begin errors++; $display("FAIL b2b_full%0d: got %b expected 1", run, user_tx_full); end
            for (int n = 0; n < 6 * nbits * BT && idle_cyc < 0; n++) begin
                if (fall_cyc < 0 && !serial_tx) fall_cyc = cyc;
                if (user_rx_val) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL b2b_extra%0d: unexpected byte %h", run, user_rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({user_rx_parity_err, user_rx_frame_err, user_rx_data} !== {2'b00, e}) begin
                            errors++; $display("FAIL b2b_rx%0d: got %h expected %h", run,
                                               {user_rx_parity_err, user_rx_frame_err, user_rx_data}, {2'b00, e});
                        end
                    end
                end
                if (fall_cyc >= 0 && user_tx_idle) idle_cyc = cyc;
                @(negedge fpga_clk);
            end
            checks++;
            if (fall_cyc < 0 || idle_cyc < 0 || idle_cyc - fall_cyc != 5 * nbits * BT) begin
                errors++; $display("FAIL b2b_gapless%0d: got %0d cycles expected %0d", run, idle_cyc - fall_cyc, 5 * nbits * BT);
            end
            checks++;
            if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing%0d: got %0d left expected 0", run, exp_q.size()); end
            user_rx_rdy = 1'b0;
            repeat (BT) @(negedge fpga_clk);
        end
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        bit ok;
        loop_en = 1'b1; parity_en = 1'b0; two_stop = 1'b0; user_rx_rdy = 1'b0;
        d = 8'($urandom) & 8'hF7;
        tx_write(d);
        tx_write(8'($urandom));
        wait_fall(4 * DIV, ok);
        repeat (BT / 2 + 4 * BT) @(negedge fpga_clk);
        checks++;
        if (!ok || serial_tx !== 1'b0) begin errors++; $display("FAIL rst_bit3: got %b expected 0", serial_tx); end
        user_rst = 1'b1;
        @(negedge fpga_clk);
        checks++;
        if ({serial_tx, user_tx_idle} !== 2'b11) begin
            errors++; $display("FAIL rst_mid: got %b expected 11", {serial_tx, user_tx_idle});
        end
        user_rst = 1'b0;
        repeat (1500) @(negedge fpga_clk);
        checks++;
        if ({user_rx_val, serial_tx, user_tx_idle} !== 3'b011) begin
            errors++; $display("FAIL rst_after: got %b expected 011", {user_rx_val, serial_tx, user_tx_idle});
        end
    endtask

    initial begin
        @(negedge fpga_clk);
        test_reset();
        test_loopback_8n1();
        test_parity();
        test_random_rx();
        test_frame_err();
        test_overflow();
        test_false_start();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
